// File: rtl/npu_sequencer_pkg.sv
// Shared op codes, parameter-register selects and FSM state encoding for the NPU sequencer.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package pkg_npu_seq;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_WB,
        ST_MOVE,
        ST_MTAIL
    } seq_state_e;

    localparam logic [3:0] OP_OS   = 4'b0000;
    localparam logic [3:0] OP_MOVE = 4'b0001;
    localparam logic [3:0] OP_WREG = 4'b1100;
    localparam logic [3:0] OP_PERF = 4'b1101;

    localparam logic [1:0] SEL_K   = 2'd0;
    localparam logic [1:0] SEL_LEN = 2'd1;
    localparam logic [1:0] SEL_SRC = 2'd2;
    localparam logic [1:0] SEL_DST = 2'd3;

    // 4'b10xx codes are reserved slots that are accepted and ignored.
    function automatic logic op_is_nop(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/npu_sequencer_addr_gen.sv
// Address/counter generator: emits base+i for i=0..len-1, one address per cycle after start.
// Latency: first address valid the cycle after start_i; len=0 starts are ignored.
// Backpressure: none; runs to completion once started.
module npu_seq_addr_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [CNT_W-1:0]      base_i,
    input  logic [CNT_W-1:0]      len_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  valid_o,
    output logic                  last_o
);

    // Sum is formed at the wider of the two widths so the base is zero-extended
    // before the add and the result wraps modulo 2^ADDR_WIDTH.
    localparam int SW = (ADDR_WIDTH > CNT_W) ? ADDR_WIDTH : CNT_W;

    logic [CNT_W-1:0] base_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] idx_q;
    logic             valid_q;
    logic [SW-1:0]    sum;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            base_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else if (start_i && (len_i != '0)) begin
            base_q  <= base_i;
            len_q   <= len_i;
            idx_q   <= '0;
            valid_q <= 1'b1;
        end else if (valid_q) begin
            if (last_o) begin
                valid_q <= 1'b0;
            end else begin
                idx_q <= idx_q + CNT_W'(1);
            end
        end
    end

    assign last_o  = valid_q && (idx_q == (len_q - CNT_W'(1)));
    assign sum     = SW'(base_q) + SW'(idx_q);
    assign addr_o  = valid_q ? sum[ADDR_WIDTH-1:0] : '0;
    assign valid_o = valid_q;

endmodule

// File: rtl/npu_sequencer.sv
// NPU op sequencer: OS compute (clear/stream/drain/writeback) and data move; NPU_SEQ_PERF_EN adds a busy-cycle counter.
// Latency: OS takes 1+K+(K>0)+ARRAY_DIM cycles, move LEN+1 cycles; done_o pulses on return to IDLE.
// Backpressure: cmd_ready_o only in IDLE; commands while busy are dropped and flagged on err_o.
module npu_sequencer
    import pkg_npu_seq::*;
#(
    parameter int DWidth     = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int ARRAY_DIM  = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [3:0]            cmd_op_i,
    input  logic [1:0]            cmd_sel_i,
    input  logic [CNT_W-1:0]      cmd_wdata_i,
    output logic                  mem_ren_o,
    output logic [ADDR_WIDTH-1:0] mem_raddr_o,
    output logic                  pe_en_o,
    output logic                  pe_clr_o,
    output logic                  omem_wen_o,
    output logic [ADDR_WIDTH-1:0] omem_waddr_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
`ifdef NPU_SEQ_PERF_EN
    ,
    output logic [31:0]           perf_cycles_o
`endif
);

    if (DWidth < 1 || ARRAY_DIM < 1) begin : g_param_chk
        $error("npu_sequencer: DWidth and ARRAY_DIM must be at least 1");
    end

    seq_state_e       state_q;
    logic [CNT_W-1:0] k_q, len_q, src_q, dst_q;
    logic             pe_clr_q, pe_en_q, done_q, err_q, mv_first_q;

    logic             accept, op_ok;
    logic             rd_start, rd_vld, rd_last;
    logic             wr_start, wr_vld, wr_last;
    logic [CNT_W-1:0] rd_len, wr_len;

    assign accept = cmd_valid_i && (state_q == ST_IDLE);

    always_comb begin
        op_ok = (cmd_op_i == OP_OS) || (cmd_op_i == OP_MOVE) ||
                op_is_nop(cmd_op_i) || (cmd_op_i == OP_WREG);
`ifdef NPU_SEQ_PERF_EN
        if (cmd_op_i == OP_PERF) op_ok = 1'b1;
`endif
    end

    // Reads start in CLEAR for OS (so STREAM sees the first address) and at
    // acceptance for a move; writes trail a move's reads by exactly one cycle.
    assign rd_start = (state_q == ST_CLEAR) || (accept && (cmd_op_i == OP_MOVE));
    assign rd_len   = (state_q == ST_CLEAR) ? k_q : len_q;
    assign wr_start = (state_q == ST_DRAIN) || ((state_q == ST_CLEAR) && (k_q == '0)) ||
                      mv_first_q;
    assign wr_len   = mv_first_q ? len_q : CNT_W'(ARRAY_DIM);

    npu_seq_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .CNT_W(CNT_W)) u_rd_gen (
        .clk     (clk),
        .rst_i   (rst_i),
        .start_i (rd_start),
        .base_i  (src_q),
        .len_i   (rd_len),
        .addr_o  (mem_raddr_o),
        .valid_o (rd_vld),
        .last_o  (rd_last)
    );

    npu_seq_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .CNT_W(CNT_W)) u_wr_gen (
        .clk     (clk),
        .rst_i   (rst_i),
        .start_i (wr_start),
        .base_i  (dst_q),
        .len_i   (wr_len),
        .addr_o  (omem_waddr_o),
        .valid_o (wr_vld),
        .last_o  (wr_last)
    );

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            len_q      <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            pe_clr_q   <= 1'b0;
            pe_en_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mv_first_q <= 1'b0;
        end else begin
            pe_clr_q   <= 1'b0;
            done_q     <= 1'b0;
            mv_first_q <= 1'b0;
            err_q      <= (cmd_valid_i && (state_q != ST_IDLE)) || (accept && !op_ok);
            // PE accumulate follows compute-stream reads only; move reads bypass the array.
            pe_en_q    <= rd_vld && (state_q == ST_STREAM);
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        case (cmd_op_i)
                            OP_OS: begin
                                state_q  <= ST_CLEAR;
                                pe_clr_q <= 1'b1;
                            end
                            OP_MOVE: begin
                                if (len_q == '0) begin
                                    done_q <= 1'b1;
                                end else begin
                                    state_q    <= ST_MOVE;
                                    mv_first_q <= 1'b1;
                                end
                            end
                            OP_WREG: begin
                                case (cmd_sel_i)
                                    SEL_K:   k_q   <= cmd_wdata_i;
                                    SEL_LEN: len_q <= cmd_wdata_i;
                                    SEL_SRC: src_q <= cmd_wdata_i;
                                    SEL_DST: dst_q <= cmd_wdata_i;
                                endcase
                            end
                            default: ;
                        endcase
                    end
                end
                ST_CLEAR:  state_q <= (k_q == '0) ? ST_WB : ST_STREAM;
                ST_STREAM: if (rd_last) state_q <= ST_DRAIN;
                ST_DRAIN:  state_q <= ST_WB;
                ST_WB: begin
                    if (wr_last) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                ST_MOVE:   if (rd_last) state_q <= ST_MTAIL;
                ST_MTAIL: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b1;
                end
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef NPU_SEQ_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            perf_q <= '0;
        end else if (accept && (cmd_op_i == OP_PERF) && (cmd_sel_i == SEL_DST)) begin
            perf_q <= '0;
        end else if (busy_o && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles_o = perf_q;
`endif

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign mem_ren_o   = rd_vld;
    assign omem_wen_o  = wr_vld;
    assign pe_en_o     = pe_en_q;
    assign pe_clr_o    = pe_clr_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_npu_sequencer.sv
// Self-checking bench for npu_sequencer: per-cycle output traces compared against a list-based op model.
module tb_npu_sequencer;

    localparam int AW = 16;
    localparam int CW = 16;
    localparam int AD = 4;

    typedef struct packed {
        logic          ready;
        logic          busy;
        logic          done;
        logic          err;
        logic          clr;
        logic          ren;
        logic [AW-1:0] ra;
        logic          pe;
        logic          wen;
        logic [AW-1:0] wa;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [3:0]    cmd_op_i;
    logic [1:0]    cmd_sel_i;
    logic [CW-1:0] cmd_wdata_i;
    logic          mem_ren_o;
    logic [AW-1:0] mem_raddr_o;
    logic          pe_en_o;
    logic          pe_clr_o;
    logic          omem_wen_o;
    logic [AW-1:0] omem_waddr_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
`ifdef NPU_SEQ_PERF_EN
    logic [31:0]   perf_cycles_o;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    obs_t exp_q[$];
    obs_t got_q[$];
    obs_t idle_obs;

    always #5 clk = ~clk;

    npu_sequencer #(
        .DWidth(8), .ADDR_WIDTH(AW), .ARRAY_DIM(AD), .CNT_W(CW)
    ) dut (
`ifdef NPU_SEQ_PERF_EN
        .perf_cycles_o (perf_cycles_o),
`endif
        .clk          (clk),
        .rst_i        (rst_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_op_i     (cmd_op_i),
        .cmd_sel_i    (cmd_sel_i),
        .cmd_wdata_i  (cmd_wdata_i),
        .mem_ren_o    (mem_ren_o),
        .mem_raddr_o  (mem_raddr_o),
        .pe_en_o      (pe_en_o),
        .pe_clr_o     (pe_clr_o),
        .omem_wen_o   (omem_wen_o),
        .omem_waddr_o (omem_waddr_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    function automatic obs_t sample();
        obs_t s;
        s.ready = cmd_ready_o;  s.busy = busy_o;    s.done = done_o;
        s.err   = err_o;        s.clr  = pe_clr_o;  s.ren  = mem_ren_o;
        s.ra    = mem_raddr_o;  s.pe   = pe_en_o;   s.wen  = omem_wen_o;
        s.wa    = omem_waddr_o;
        return s;
    endfunction

    // Expected trace of an OS op: one clear cycle, K reads, a drain cycle when K>0,
    // ARRAY_DIM writes; the PE enable is the previous cycle's read strobe.
    task automatic build_os(input int k, input int src, input int dst);
        int   nb;
        logic prev;
        obs_t e;
        exp_q.delete();
        nb   = 1 + k + ((k > 0) ? 1 : 0) + AD;
        prev = 1'b0;
        for (int c = 0; c < nb; c++) begin
            e = '0;
            e.busy = 1'b1;
            if (c == 0) begin
                e.clr = 1'b1;
            end else if (c <= k) begin
                e.ren = 1'b1;
                e.ra  = AW'(src + c - 1);
            end else if (c >= nb - AD) begin
                e.wen = 1'b1;
                e.wa  = AW'(dst + c - (nb - AD));
            end
            e.pe = prev;
            prev = e.ren;
            exp_q.push_back(e);
        end
        e = idle_obs;
        e.done = 1'b1;
        exp_q.push_back(e);
    endtask

    // Expected trace of a move: LEN reads, each echoed as a write one cycle later.
    task automatic build_move(input int len, input int src, input int dst);
        int   nb;
        obs_t e;
        exp_q.delete();
        nb = (len == 0) ? 0 : len + 1;
        for (int c = 0; c < nb; c++) begin
            e = '0;
            e.busy = 1'b1;
            if (c < len) begin
                e.ren = 1'b1;
                e.ra  = AW'(src + c);
            end
            if (c >= 1) begin
                e.wen = 1'b1;
                e.wa  = AW'(dst + c - 1);
            end
            exp_q.push_back(e);
        end
        e = idle_obs;
        e.done = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic add_err(input int idx);
        obs_t e;
        e = exp_q[idx];
        e.err = 1'b1;
        exp_q[idx] = e;
    endtask

    task automatic write_reg(input logic [1:0] sel, input int d);
        @(negedge clk);
        cmd_valid_i = 1'b1; cmd_op_i = 4'b1100; cmd_sel_i = sel; cmd_wdata_i = CW'(d);
        @(negedge clk);
        cmd_valid_i = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op);
        @(negedge clk);
        cmd_valid_i = 1'b1; cmd_op_i = op;
    endtask

    // Samples n cycles after the issued command; optionally strobes a move command at cycle inj.
    task automatic capture(input int n, input int inj);
        got_q.delete();
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            cmd_valid_i = (c == inj);
            if (c == inj) cmd_op_i = 4'b0001;
            got_q.push_back(sample());
        end
        cmd_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        obs_t g;
        g = sample();
        n_checks++;
        if (g !== idle_obs) begin
            n_fail++;
            $display("FAIL reset_state got=%h expected=%h", g, idle_obs);
        end
    endtask

    task automatic test_os_basic();
        int dc;
        write_reg(2'd0, 3); write_reg(2'd2, 'h10); write_reg(2'd3, 'h40);
        build_os(3, 'h10, 'h40);
        issue(4'b0000);
        capture(exp_q.size(), -1);
        dc = -1;
        for (int c = 0; c < exp_q.size(); c++) begin
            n_checks++;
            if (got_q[c] !== exp_q[c]) begin
                n_fail++;
                $display("FAIL os_basic cyc=%0d got=%h expected=%h", c, got_q[c], exp_q[c]);
            end
            if (got_q[c].done && dc < 0) dc = c;
        end
        n_checks++;
        if (dc != 9) begin
            n_fail++;
            $display("FAIL os_done_latency got=%0d expected=9", dc);
        end
    endtask

    task automatic test_move_basic();
        write_reg(2'd1, 4); write_reg(2'd2, 'h20); write_reg(2'd3, 'h80);
        build_move(4, 'h20, 'h80);
        issue(4'b0001);
        capture(exp_q.size(), -1);
        for (int c = 0; c < exp_q.size(); c++) begin
            n_checks++;
            if (got_q[c] !== exp_q[c]) begin
                n_fail++;
                $display("FAIL move_basic cyc=%0d got=%h expected=%h", c, got_q[c], exp_q[c]);
            end
        end
    endtask

    task automatic test_zero_len();
        write_reg(2'd0, 0); write_reg(2'd3, 'h30);
        build_os(0, 'h20, 'h30);
        issue(4'b0000);
        capture(exp_q.size(), -1);
        for (int c = 0; c < exp_q.size(); c++) begin
            n_checks++;
            if (got_q[c] !== exp_q[c]) begin
                n_fail++;
                $display("FAIL os_k0 cyc=%0d got=%h expected=%h", c, got_q[c], exp_q[c]);
            end
        end
        write_reg(2'd1, 0);
        build_move(0, 'h20, 'h30);
        exp_q.push_back(idle_obs);
        issue(4'b0001);
        capture(exp_q.size(), -1);
        for (int c = 0; c < exp_q.size(); c++) begin
            n_checks++;
            if (got_q[c] !== exp_q[c]) begin
                n_fail++;
                $display("FAIL move_len0 cyc=%0d got=%h expected=%h", c, got_q[c], exp_q[c]);
            end
        end
    endtask

    task automatic test_errors();
        logic [3:0] ops[3];
        logic       bad[3];
        obs_t       e;
        write_reg(2'd0, 3); write_reg(2'd2, 'h10); write_reg(2'd3, 'h40);
        build_os(3, 'h10, 'h40);
        add_err(3);
        issue(4'b0000);
        capture(exp_q.size(), 2);
        for (int c = 0; c < exp_q.size(); c++) begin
            n_checks++;
            if (got_q[c] !== exp_q[c]) begin
                n_fail++;
                $display("FAIL busy_cmd cyc=%0d got=%h expected=%h", c, got_q[c], exp_q[c]);
            end
        end
        ops[0] = 4'b0111; bad[0] = 1'b1;
        ops[1] = 4'b1010; bad[1] = 1'b0;
        ops[2] = 4'b1101; bad[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.delete();
            e = idle_obs;
            e.err = bad[i];
            exp_q.push_back(e);
            exp_q.push_back(idle_obs);
            issue(ops[i]);
            capture(2, -1);
            for (int c = 0; c < 2; c++) begin
                n_checks++;
                if (got_q[c] !== exp_q[c]) begin
                    n_fail++;
                    $display("FAIL idle_op_%b cyc=%0d got=%h expected=%h", ops[i], c, got_q[c], exp_q[c]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        write_reg(2'd0, 3); write_reg(2'd2, 'hFFFF); write_reg(2'd3, 'hFFFE);
        build_os(3, 'hFFFF, 'hFFFE);
        issue(4'b0000);
        capture(exp_q.size(), -1);
        for (int c = 0; c < exp_q.size(); c++) begin
            n_checks++;
            if (got_q[c] !== exp_q[c]) begin
                n_fail++;
                $display("FAIL addr_wrap cyc=%0d got=%h expected=%h", c, got_q[c], exp_q[c]);
            end
        end
    endtask

    task automatic test_reset_mid_wb();
        obs_t g;
        write_reg(2'd0, 1); write_reg(2'd2, 5); write_reg(2'd3, 7);
        build_os(1, 5, 7);
        issue(4'b0000);
        capture(4, -1);
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (got_q[c] !== exp_q[c]) begin
                n_fail++;
                $display("FAIL pre_reset cyc=%0d got=%h expected=%h", c, got_q[c], exp_q[c]);
            end
        end
        #2 rst_i = 1'b1;
        #1 g = sample();
        n_checks++;
        if (g !== idle_obs) begin
            n_fail++;
            $display("FAIL reset_mid_wb got=%h expected=%h", g, idle_obs);
        end
        @(negedge clk);
        rst_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            g = sample();
            n_checks++;
            if (g !== idle_obs) begin
                n_fail++;
                $display("FAIL post_reset cyc=%0d got=%h expected=%h", c, g, idle_obs);
            end
        end
        build_os(0, 0, 0);
        issue(4'b0000);
        capture(exp_q.size(), -1);
        for (int c = 0; c < exp_q.size(); c++) begin
            n_checks++;
            if (got_q[c] !== exp_q[c]) begin
                n_fail++;
                $display("FAIL regs_cleared cyc=%0d got=%h expected=%h", c, got_q[c], exp_q[c]);
            end
        end
    endtask

    task automatic test_random();
        int is_os, n, src, dst, inj, nb;
        for (int it = 0; it < 12; it++) begin
            is_os = $urandom_range(0, 1);
            n     = $urandom_range(0, 6);
            src   = $urandom_range(0, 65535);
            dst   = $urandom_range(0, 65535);
            write_reg(is_os ? 2'd0 : 2'd1, n);
            write_reg(2'd2, src);
            write_reg(2'd3, dst);
            if (is_os != 0) build_os(n, src, dst);
            else            build_move(n, src, dst);
            nb  = exp_q.size() - 1;
            inj = -1;
            if (nb > 0 && $urandom_range(0, 1) == 1) begin
                inj = $urandom_range(0, nb - 1);
                add_err(inj + 1);
            end
            issue(is_os ? 4'b0000 : 4'b0001);
            capture(exp_q.size(), inj);
            for (int c = 0; c < exp_q.size(); c++) begin
                n_checks++;
                if (got_q[c] !== exp_q[c]) begin
                    n_fail++;
                    $display("FAIL random it=%0d os=%0d n=%0d cyc=%0d got=%h expected=%h",
                             it, is_os, n, c, got_q[c], exp_q[c]);
                end
            end
        end
    endtask

    initial begin
        idle_obs       = '0;
        idle_obs.ready = 1'b1;
        rst_i       = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_op_i    = 4'b0000;
        cmd_sel_i   = 2'd0;
        cmd_wdata_i = '0;
        #22;
        @(negedge clk);
        rst_i = 1'b0;
        test_reset();
        test_os_basic();
        test_move_basic();
        test_zero_len();
        test_errors();
        test_wrap();
        test_reset_mid_wb();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1);
    end

endmodule

// File: doc/npu_sequencer.md
NPU_SEQUENCER -- requirements
Module: npu_sequencer

Interface
REQ-001 SHALL have parameter DWidth, default 8, PE operand width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, memory address width.
REQ-003 SHALL have parameter ARRAY_DIM, default 4, number of PE result words written back per compute op.
REQ-004 SHALL have parameter CNT_W, default 16, width of length/base registers.
REQ-005 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-006 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-007 SHALL have ports cmd_valid_i (in, 1, command strobe) and cmd_ready_o (out, 1, command accepted this cycle).
REQ-008 SHALL have ports cmd_op_i (in, 4, decoded op type), cmd_sel_i (in, 2, parameter register select) and cmd_wdata_i (in, CNT_W, command data).
REQ-009 SHALL have ports mem_ren_o (out, 1, source read enable) and mem_raddr_o (out, ADDR_WIDTH, source read address).
REQ-010 SHALL have ports pe_en_o (out, 1, PE accumulate enable) and pe_clr_o (out, 1, PE accumulator clear).
REQ-011 SHALL have ports omem_wen_o (out, 1, OMEM write enable) and omem_waddr_o (out, ADDR_WIDTH, OMEM write address).
REQ-012 SHALL have ports busy_o (out, 1, op in progress), done_o (out, 1, op-complete pulse) and err_o (out, 1, rejected-command pulse).

Function
REQ-013 Parameter registers: sel 0 = K, 1 = LEN, 2 = SRC, 3 = DST; cmd_op_i=4'b1100 in IDLE SHALL write cmd_wdata_i to the selected register.
REQ-014 cmd_ready_o SHALL equal (state==IDLE); a command is accepted when cmd_valid_i & cmd_ready_o.
REQ-015 cmd_op_i 4'b0000 SHALL start OS compute, 4'b0001 SHALL start data move; 4'b1000-4'b1011 SHALL be accepted with no action; all other codes SHALL pulse err_o for one cycle.
REQ-016 cmd_valid_i while not IDLE SHALL be ignored and SHALL pulse err_o one cycle later.
REQ-017 States: IDLE, CLEAR, STREAM, DRAIN, WB, MOVE, MTAIL.
REQ-018 OS: IDLE->CLEAR (pe_clr_o=1 for 1 cycle)->STREAM (K cycles, mem_ren_o=1, mem_raddr_o=SRC+i, i=0..K-1)->DRAIN (1 cycle)->WB (ARRAY_DIM cycles, omem_wen_o=1, omem_waddr_o=DST+j)->IDLE.
REQ-019 pe_en_o SHALL be mem_ren_o delayed by one cycle (1-cycle memory read latency); pe_en_o is asserted in DRAIN.
REQ-020 K=0 SHALL go CLEAR->WB directly, with no reads and no pe_en_o.
REQ-021 Move: MOVE for LEN cycles reading SRC+i; omem_wen_o SHALL follow each read by one cycle at DST+i; MTAIL issues the last write then IDLE.
REQ-022 LEN=0 SHALL return to IDLE in one cycle with done_o and no reads/writes.
REQ-023 done_o SHALL pulse one cycle on the cycle the FSM re-enters IDLE; busy_o = (state!=IDLE).
REQ-024 Address arithmetic SHALL zero-extend CNT_W values to ADDR_WIDTH, wrapping modulo 2^ADDR_WIDTH.
REQ-025 Parameter registers SHALL be sampled at op start; the counter SHALL be CNT_W wide, so K, LEN up to 2^CNT_W-1 are legal.

Reset
REQ-026 rst_i SHALL force IDLE and clear all parameter registers, counters and outputs to 0, except cmd_ready_o=1, mid-operation included, with no done_o pulse.

Configuration
REQ-027 With NPU_SEQ_PERF_EN defined, output perf_cycles_o (32) SHALL count cycles with busy_o=1, saturating at all-ones, cleared by reset or by a write with cmd_sel_i=3 and cmd_op_i=4'b1101; without it the port and counter SHALL be absent and 4'b1101 SHALL raise err_o.

Structure
REQ-028 Op-code constants and the state enum SHALL live in package pkg_npu_seq; address ranges stay in pkg_memorymap.
REQ-029 Address/counter generation SHALL be a sub-module npu_seq_addr_gen (base, length, start -> addr, valid, last).

Verification
REQ-030 Write K=3, SRC=0x10, DST=0x40, op 0000 -> pe_clr 1 cycle; reads 0x10-0x12; pe_en 3 cycles; writes 0x40-0x43; done_o after 9 cycles.
REQ-031 LEN=4, SRC=0x20, DST=0x80, op 0001 -> reads 0x20-0x23, writes 0x80-0x83 each one cycle later, single done_o.
REQ-032 K=0 op 0000 -> no mem_ren_o, 4 writes; LEN=0 op 0001 -> done_o next cycle, no writes.
REQ-033 op 0001 issued during STREAM -> err_o pulse, sequence unaffected; op 4'b0111 in IDLE -> err_o, stays IDLE.
REQ-034 rst_i asserted mid-WB -> outputs 0 immediately, cmd_ready_o=1, no done_o; SRC=0xFFFF with ADDR_WIDTH=16 wraps to 0x0000.
